reg_writeback_unit: RTL and testbench
=====================================

Name: reg_writeback_unit

Overview:
- Write-side driver for the processor's 16x32 register file. Merges ALU results and load results into the file's single write port (wrtEn/dr/dIn) through a priority arbiter and a small ALU skid queue.
- Keeps a per-register pending scoreboard.
- Supplies forwarding data and busy flags for the two decode-stage source registers (sr1/sr2), covering writes not yet committed.

Parameters:
- BIT_WIDTH, 32, data width of one register.
- REG_WIDTH, 4, register index width.
- REG_SIZE, 1 << REG_WIDTH, number of registers.
- Q_DEPTH, 2, ALU skid-queue entries (power of 2, >= 2).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- issueEn  in  1  issued instruction will write issueDr; sets its pending bit.
- issueDr  in  REG_WIDTH  destination of the issued instruction.
- aluVld  in  1  ALU result valid this cycle.
- aluDr  in  REG_WIDTH  ALU result destination.
- aluData  in  BIT_WIDTH  ALU result.
- aluRdy  out  1  skid queue can accept; equals !full.
- ldVld  in  1  load result valid; always accepted.
- ldDr  in  REG_WIDTH  load destination.
- ldData  in  BIT_WIDTH  load data.
- wrtEn  out  1  register-file write enable (registered).
- dr  out  REG_WIDTH  register-file write index (registered).
- dIn  out  BIT_WIDTH  register-file write data (registered).
- sr1, sr2  in  REG_WIDTH  decode-stage source indices.
- fwd1Vld, fwd2Vld  out  1  forwarding hit for sr1/sr2.
- fwd1Data, fwd2Data  out  BIT_WIDTH  forwarded value.
- busy1, busy2  out  1  source pending and not forwardable; decode must stall.
- pendingMask  out  REG_SIZE  scoreboard bits.
- ovfErr  out  1  sticky: aluVld asserted while aluRdy low.

Behaviour:
- Reset values: wrtEn=0, dr=0, dIn=0, queue empty, aluRdy=1, pendingMask=0, ovfErr=0, fwd*Vld=0. Reset mid-operation discards all queued and in-flight results.
- Arbitration each cycle, in priority order:
  - (1) ldVld → output register loads {1, ldDr, ldData}.
  - (2) otherwise, queue non-empty → pop head into the output register.
  - (3) otherwise, aluVld → ALU result bypasses the queue into the output register.
  - (4) otherwise → wrtEn=0 next cycle; dr/dIn hold.
- Enqueue: aluVld && aluRdy pushes when the ALU result is not consumed by bypass, i.e. when ldVld=1 or the queue is non-empty. Push and pop in the same cycle are legal; occupancy is unchanged.
- Latency: an uncontested ALU or load result presented in cycle N appears on wrtEn/dr/dIn in cycle N+1. The register file commits at the end of N+1.
- Ordering: ALU results commit in arrival order. Loads may overtake queued ALU results.
- aluVld && !aluRdy: the result is dropped and ovfErr is set; it clears only on reset.
- Scoreboard:
  - pending[issueDr] is set at the edge when issueEn=1.
  - pending[r] is cleared at the edge where the output register is loaded with a write to r.
  - Simultaneous set and clear of the same r: set wins.
  - Issue control guarantees at most one outstanding write per register; the unit does not check this.
- Forwarding is combinational from registered state only; raw ALU/load inputs are never forwarded.
  - fwdNVld=1 when srN matches the output register (wrtEn=1) or any valid queue entry.
  - On multiple matches, the output register wins, then the oldest queue entry.
  - fwdNData = matching data; 0 when there is no hit.
- busyN = pendingMask[srN] && !fwdNVld.
- Width: all data passes through unmodified; there is no special case for register 0.

Decomposition:
- Shared package wb_pkg:
  - BIT_WIDTH and REG_WIDTH defaults.
  - wb_entry_t = {dr, data}.
  - Source-select enum {SRC_NONE, SRC_LD, SRC_Q, SRC_ALU}.
- One sub-module, wb_skid_fifo: parameterised Q_DEPTH circular buffer with wrap-around read/write pointers and count. It exposes full, empty, head, and all entries (for the forwarding compare).

Test Plan:
- Reset then idle → wrtEn=0, aluRdy=1, pendingMask=0, ovfErr=0 for 10 cycles.
- aluVld, aluDr=3, aluData=0x11 in cycle 5 with queue empty → cycle 6: wrtEn=1, dr=3, dIn=0x11; after the edge, regfile r3 reads 0x11.
- Load and ALU results on the same cycle:
  - Stimulus: cycle 5 ldVld(r4=0xAA) and aluVld(r5=0xBB); cycle 6 aluVld(r6=0xCC).
  - Required output sequence: r4=0xAA, then r5=0xBB, then r6=0xCC, on consecutive cycles.
  - Required forwarding: sr1=5 gives fwd1Vld=1 with 0xBB while r5 is queued.
- Queue overflow:
  - Stimulus: hold ldVld for 4 cycles while presenting 3 ALU results.
  - Required: aluRdy=0 after 2 pushes; the third result is dropped and ovfErr=1.
  - Required: queued results drain after the loads end.
- Scoreboard:
  - issueEn with issueDr=7 → pendingMask[7]=1; busy1=1 for sr1=7.
  - A load to r7 arriving later → fwd1Vld=1, busy1=0 during the output cycle; pending[7]=0 after that cycle.
  - issueEn for r7 on the same cycle as the clear edge → pending[7] stays 1.
- Reset asserted with 2 queued entries and wrtEn=1 → next cycle queue empty, wrtEn=0, pendingMask=0; the dropped results never reach the regfile.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register write-back path: default widths, queue entry
// layout and the arbiter source select.
package wb_pkg;

  localparam int WB_BIT_WIDTH = 32;
  localparam int WB_REG_WIDTH = 4;

  typedef struct packed {
    logic [WB_REG_WIDTH-1:0] dr;
    logic [WB_BIT_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LD,
    SRC_Q,
    SRC_ALU
  } src_sel_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Circular skid buffer for ALU results; also presents every slot in age order
// (index 0 = oldest) so the owner can run a forwarding compare.
module wb_skid_fifo #(
  parameter int DW    = 36,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DW-1:0]             wdata,
  output logic                      full,
  output logic                      empty,
  output logic [DW-1:0]             head,
  output logic [DEPTH-1:0][DW-1:0]  entries,
  output logic [DEPTH-1:0]          entry_vld
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [PW:0]              count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_comb begin
    entries   = '0;
    entry_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]   = mem[rd_ptr + PW'(i)];
      entry_vld[i] = ((PW+1)'(i) < count);
    end
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write port driver: arbitrates loads, queued and bypassed ALU
// results, tracks pending destinations and forwards uncommitted values.
module reg_writeback_unit
  import wb_pkg::*;
#(
  parameter int BIT_WIDTH = WB_BIT_WIDTH,
  parameter int REG_WIDTH = WB_REG_WIDTH,
  parameter int REG_SIZE  = 1 << REG_WIDTH,
  parameter int Q_DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issueEn,
  input  logic [REG_WIDTH-1:0] issueDr,
  input  logic                 aluVld,
  input  logic [REG_WIDTH-1:0] aluDr,
  input  logic [BIT_WIDTH-1:0] aluData,
  output logic                 aluRdy,
  input  logic                 ldVld,
  input  logic [REG_WIDTH-1:0] ldDr,
  input  logic [BIT_WIDTH-1:0] ldData,
  output logic                 wrtEn,
  output logic [REG_WIDTH-1:0] dr,
  output logic [BIT_WIDTH-1:0] dIn,
  input  logic [REG_WIDTH-1:0] sr1,
  input  logic [REG_WIDTH-1:0] sr2,
  output logic                 fwd1Vld,
  output logic                 fwd2Vld,
  output logic [BIT_WIDTH-1:0] fwd1Data,
  output logic [BIT_WIDTH-1:0] fwd2Data,
  output logic                 busy1,
  output logic                 busy2,
  output logic [REG_SIZE-1:0]  pendingMask,
  output logic                 ovfErr
);

  localparam int EW = REG_WIDTH + BIT_WIDTH;

  src_sel_t                    sel;
  logic                        q_push;
  logic                        q_pop;
  logic                        q_full;
  logic                        q_empty;
  logic [EW-1:0]               q_head;
  logic [Q_DEPTH-1:0][EW-1:0]  q_ent;
  logic [Q_DEPTH-1:0]          q_vld;
  logic [REG_WIDTH-1:0]        nxt_dr;
  logic [BIT_WIDTH-1:0]        nxt_data;

  wb_skid_fifo #(
    .DW    (EW),
    .DEPTH (Q_DEPTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .pop       (q_pop),
    .wdata     ({aluDr, aluData}),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head),
    .entries   (q_ent),
    .entry_vld (q_vld)
  );

  assign aluRdy = !q_full;

  always_comb begin
    sel = SRC_NONE;
    if (ldVld)         sel = SRC_LD;
    else if (!q_empty) sel = SRC_Q;
    else if (aluVld)   sel = SRC_ALU;
  end

  always_comb begin
    nxt_dr   = '0;
    nxt_data = '0;
    unique case (sel)
      SRC_LD:  begin nxt_dr = ldDr;                   nxt_data = ldData;                 end
      SRC_Q:   begin nxt_dr = q_head[EW-1 -: REG_WIDTH]; nxt_data = q_head[BIT_WIDTH-1:0]; end
      SRC_ALU: begin nxt_dr = aluDr;                  nxt_data = aluData;                end
      default: ;
    endcase
  end

  // An ALU result is queued only when it cannot take the bypass path.
  assign q_push = aluVld && aluRdy && (ldVld || !q_empty);
  assign q_pop  = (sel == SRC_Q);

  always_ff @(posedge clk) begin
    if (reset) begin
      wrtEn <= 1'b0;
      dr    <= '0;
      dIn   <= '0;
    end else if (sel != SRC_NONE) begin
      wrtEn <= 1'b1;
      dr    <= nxt_dr;
      dIn   <= nxt_data;
    end else begin
      wrtEn <= 1'b0;
    end
  end

  // Set is written last so a same-edge issue to the retiring register wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pendingMask <= '0;
    end else begin
      if (sel != SRC_NONE) pendingMask[nxt_dr]  <= 1'b0;
      if (issueEn)         pendingMask[issueDr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                 ovfErr <= 1'b0;
    else if (aluVld && q_full) ovfErr <= 1'b1;
  end

  function automatic logic [BIT_WIDTH:0] fwd_lookup(
    input logic [REG_WIDTH-1:0]       sr,
    input logic                       out_vld,
    input logic [REG_WIDTH-1:0]       out_dr,
    input logic [BIT_WIDTH-1:0]       out_data,
    input logic [Q_DEPTH-1:0][EW-1:0] ent,
    input logic [Q_DEPTH-1:0]         vld
  );
    logic                 hit;
    logic [BIT_WIDTH-1:0] d;
    hit = 1'b0;
    d   = '0;
    // Scan youngest to oldest so the oldest match overwrites; output reg beats all.
    for (int i = Q_DEPTH - 1; i >= 0; i--) begin
      if (vld[i] && (ent[i][EW-1 -: REG_WIDTH] == sr)) begin
        hit = 1'b1;
        d   = ent[i][BIT_WIDTH-1:0];
      end
    end
    if (out_vld && (out_dr == sr)) begin
      hit = 1'b1;
      d   = out_data;
    end
    return {hit, d};
  endfunction

  assign {fwd1Vld, fwd1Data} = fwd_lookup(sr1, wrtEn, dr, dIn, q_ent, q_vld);
  assign {fwd2Vld, fwd2Data} = fwd_lookup(sr2, wrtEn, dr, dIn, q_ent, q_vld);

  assign busy1 = pendingMask[sr1] && !fwd1Vld;
  assign busy2 = pendingMask[sr2] && !fwd2Vld;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed scenarios plus a randomized run
// against a queue-based reference model of the write-back rules.
module tb_reg_writeback_unit;
  import wb_pkg::*;

  localparam int BW = 32;
  localparam int RW = 4;
  localparam int RS = 16;
  localparam int QD = 2;

  logic          clk, reset;
  logic          issueEn, aluVld, ldVld;
  logic [RW-1:0] issueDr, aluDr, ldDr, sr1, sr2, dr;
  logic [BW-1:0] aluData, ldData, dIn, fwd1Data, fwd2Data;
  logic          aluRdy, wrtEn, fwd1Vld, fwd2Vld, busy1, busy2, ovfErr;
  logic [RS-1:0] pendingMask;

  reg_writeback_unit #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .REG_SIZE(RS), .Q_DEPTH(QD)) dut (
    .clk(clk), .reset(reset), .issueEn(issueEn), .issueDr(issueDr),
    .aluVld(aluVld), .aluDr(aluDr), .aluData(aluData), .aluRdy(aluRdy),
    .ldVld(ldVld), .ldDr(ldDr), .ldData(ldData),
    .wrtEn(wrtEn), .dr(dr), .dIn(dIn), .sr1(sr1), .sr2(sr2),
    .fwd1Vld(fwd1Vld), .fwd2Vld(fwd2Vld), .fwd1Data(fwd1Data), .fwd2Data(fwd2Data),
    .busy1(busy1), .busy2(busy2), .pendingMask(pendingMask), .ovfErr(ovfErr)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] rf [RS];
  always @(posedge clk) if (wrtEn) rf[dr] <= dIn;

  // Reference model state
  wb_entry_t     mq[$];
  logic          m_wen;
  logic [RW-1:0] m_dr;
  logic [BW-1:0] m_din;
  logic [RS-1:0] m_pend;
  logic          m_ovf;
  int            n_cmp, n_err;

  task automatic idle();
    issueEn = 0; issueDr = 0; aluVld = 0; aluDr = 0; aluData = 0;
    ldVld = 0; ldDr = 0; ldData = 0;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT samples.
  task automatic step();
    wb_entry_t e, h;
    bit rdy;
    @(posedge clk);
    if (reset) begin
      mq.delete(); m_wen = 0; m_dr = 0; m_din = 0; m_pend = 0; m_ovf = 0;
    end else begin
      rdy = (mq.size() < QD);
      if (aluVld && !rdy) m_ovf = 1;
      e.dr = aluDr; e.data = aluData;
      if (ldVld) begin
        m_wen = 1; m_dr = ldDr; m_din = ldData;
        if (aluVld && rdy) mq.push_back(e);
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        m_wen = 1; m_dr = h.dr; m_din = h.data;
        if (aluVld && rdy) mq.push_back(e);
      end else if (aluVld) begin
        m_wen = 1; m_dr = aluDr; m_din = aluData;
      end else begin
        m_wen = 0;
      end
      if (m_wen) m_pend[m_dr] = 0;
      if (issueEn) m_pend[issueDr] = 1;
    end
    @(negedge clk);
  endtask

  function automatic logic [BW:0] m_fwd(input logic [RW-1:0] sr);
    if (m_wen && m_dr == sr) return {1'b1, m_din};
    foreach (mq[i]) if (mq[i].dr == sr) return {1'b1, mq[i].data};
    return '0;
  endfunction

  task automatic test_reset();
    reset = 1; idle(); sr1 = 0; sr2 = 0;
    step(); step();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (wrtEn !== 1'b0) begin n_err++; $display("FAIL reset_wrtEn: got %b want 0", wrtEn); end
      n_cmp++; if (aluRdy !== 1'b1) begin n_err++; $display("FAIL reset_aluRdy: got %b want 1", aluRdy); end
      n_cmp++; if (pendingMask !== '0) begin n_err++; $display("FAIL reset_pending: got %h want 0", pendingMask); end
      n_cmp++; if (ovfErr !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovfErr); end
      n_cmp++; if (fwd1Vld !== 1'b0) begin n_err++; $display("FAIL reset_fwd1: got %b want 0", fwd1Vld); end
    end
  endtask

  task automatic test_alu_bypass();
    aluVld = 1; aluDr = 3; aluData = 32'h11;
    step(); idle();
    n_cmp++; if ({wrtEn, dr, dIn} !== {1'b1, 4'd3, 32'h11})
      begin n_err++; $display("FAIL bypass_out: got %b/%0d/%h want 1/3/11", wrtEn, dr, dIn); end
    step();
    n_cmp++; if (rf[3] !== 32'h11) begin n_err++; $display("FAIL bypass_rf3: got %h want 11", rf[3]); end
  endtask

  task automatic test_ld_alu();
    ldVld = 1; ldDr = 4; ldData = 32'hAA; aluVld = 1; aluDr = 5; aluData = 32'hBB;
    step();
    ldVld = 0; aluDr = 6; aluData = 32'hCC; sr1 = 5; #1;
    n_cmp++; if ({wrtEn, dr, dIn} !== {1'b1, 4'd4, 32'hAA})
      begin n_err++; $display("FAIL ldalu_first: got %b/%0d/%h want 1/4/aa", wrtEn, dr, dIn); end
    n_cmp++; if ({fwd1Vld, fwd1Data} !== {1'b1, 32'hBB})
      begin n_err++; $display("FAIL ldalu_fwd_q: got %b/%h want 1/bb", fwd1Vld, fwd1Data); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL ldalu_busy: got %b want 0", busy1); end
    step(); idle();
    n_cmp++; if ({wrtEn, dr, dIn} !== {1'b1, 4'd5, 32'hBB})
      begin n_err++; $display("FAIL ldalu_second: got %b/%0d/%h want 1/5/bb", wrtEn, dr, dIn); end
    step();
    n_cmp++; if ({wrtEn, dr, dIn} !== {1'b1, 4'd6, 32'hCC})
      begin n_err++; $display("FAIL ldalu_third: got %b/%0d/%h want 1/6/cc", wrtEn, dr, dIn); end
    step();
    n_cmp++; if (wrtEn !== 1'b0) begin n_err++; $display("FAIL ldalu_idle: got %b want 0", wrtEn); end
  endtask

  task automatic test_overflow();
    reset = 1; idle(); step(); reset = 0;
    for (int c = 0; c < 4; c++) begin
      ldVld = 1; ldDr = RW'(8 + c); ldData = 32'h100 + c;
      aluVld = (c < 3);
      aluDr = (c == 0) ? 4'd1 : (c == 1) ? 4'd2 : 4'd12;
      aluData = 32'h200 + c;
      #1;
      n_cmp++; if (aluRdy !== (c < 2))
        begin n_err++; $display("FAIL ovf_rdy_c%0d: got %b want %b", c, aluRdy, c < 2); end
      step();
      n_cmp++; if ({wrtEn, dr} !== {1'b1, RW'(8 + c)})
        begin n_err++; $display("FAIL ovf_ld_c%0d: got %b/%0d want 1/%0d", c, wrtEn, dr, 8 + c); end
      n_cmp++; if (ovfErr !== (c >= 2))
        begin n_err++; $display("FAIL ovf_err_c%0d: got %b want %b", c, ovfErr, c >= 2); end
    end
    idle(); step();
    n_cmp++; if ({wrtEn, dr, dIn} !== {1'b1, 4'd1, 32'h200})
      begin n_err++; $display("FAIL ovf_drain1: got %b/%0d/%h want 1/1/200", wrtEn, dr, dIn); end
    step();
    n_cmp++; if ({wrtEn, dr, dIn} !== {1'b1, 4'd2, 32'h201})
      begin n_err++; $display("FAIL ovf_drain2: got %b/%0d/%h want 1/2/201", wrtEn, dr, dIn); end
    n_cmp++; if (aluRdy !== 1'b1) begin n_err++; $display("FAIL ovf_rdy_after: got %b want 1", aluRdy); end
    step();
    n_cmp++; if (wrtEn !== 1'b0) begin n_err++; $display("FAIL ovf_no_third: got %b want 0", wrtEn); end
    n_cmp++; if (ovfErr !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovfErr); end
  endtask

  task automatic test_scoreboard();
    reset = 1; idle(); step(); reset = 0;
    issueEn = 1; issueDr = 7; step(); idle(); sr1 = 7; #1;
    n_cmp++; if (pendingMask[7] !== 1'b1) begin n_err++; $display("FAIL sb_set: got %b want 1", pendingMask[7]); end
    n_cmp++; if ({busy1, fwd1Vld} !== 2'b10) begin n_err++; $display("FAIL sb_busy: got %b%b want 10", busy1, fwd1Vld); end
    step();
    ldVld = 1; ldDr = 7; ldData = 32'h77; step(); idle();
    n_cmp++; if ({fwd1Vld, fwd1Data, busy1} !== {1'b1, 32'h77, 1'b0})
      begin n_err++; $display("FAIL sb_fwd_out: got %b/%h/%b want 1/77/0", fwd1Vld, fwd1Data, busy1); end
    n_cmp++; if (pendingMask[7] !== 1'b0) begin n_err++; $display("FAIL sb_clear: got %b want 0", pendingMask[7]); end
    step();
    n_cmp++; if ({pendingMask[7], busy1, fwd1Vld} !== 3'b000)
      begin n_err++; $display("FAIL sb_after: got %b%b%b want 000", pendingMask[7], busy1, fwd1Vld); end
    issueEn = 1; issueDr = 7; step();
    ldVld = 1; ldDr = 7; ldData = 32'h78; issueEn = 1; issueDr = 7; step(); idle();
    n_cmp++; if (pendingMask[7] !== 1'b1) begin n_err++; $display("FAIL sb_set_wins: got %b want 1", pendingMask[7]); end
    n_cmp++; if ({fwd1Vld, busy1} !== 2'b10) begin n_err++; $display("FAIL sb_set_fwd: got %b%b want 10", fwd1Vld, busy1); end
    step();
    n_cmp++; if ({pendingMask[7], busy1} !== 2'b11) begin n_err++; $display("FAIL sb_set_busy: got %b%b want 11", pendingMask[7], busy1); end
  endtask

  task automatic test_reset_flush();
    reset = 1; idle(); step(); reset = 0;
    ldVld = 1; ldDr = 1; ldData = 32'h301; aluVld = 1; aluDr = 2; aluData = 32'h302;
    issueEn = 1; issueDr = 9; step();
    ldDr = 3; ldData = 32'h303; aluDr = 4; aluData = 32'h304; issueEn = 0; step(); idle();
    n_cmp++; if ({wrtEn, aluRdy, pendingMask[9]} !== 3'b101)
      begin n_err++; $display("FAIL flush_pre: got %b%b%b want 101", wrtEn, aluRdy, pendingMask[9]); end
    reset = 1; step(); reset = 0;
    n_cmp++; if ({wrtEn, aluRdy} !== 2'b01) begin n_err++; $display("FAIL flush_rst: got %b%b want 01", wrtEn, aluRdy); end
    n_cmp++; if (pendingMask !== '0) begin n_err++; $display("FAIL flush_pend: got %h want 0", pendingMask); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (wrtEn !== 1'b0) begin n_err++; $display("FAIL flush_idle%0d: got %b want 0", i, wrtEn); end
    end
    n_cmp++; if (rf[2] === 32'h302 || rf[4] === 32'h304)
      begin n_err++; $display("FAIL flush_rf: got r2=%h r4=%h want neither 302/304", rf[2], rf[4]); end
  endtask

  task automatic test_random();
    logic [BW:0] f1, f2;
    reset = 1; idle(); step(); reset = 0;
    for (int n = 0; n < 500; n++) begin
      ldVld   = ($urandom_range(0, 3) == 0);
      aluVld  = $urandom_range(0, 1);
      issueEn = ($urandom_range(0, 2) == 0);
      ldDr    = RW'($urandom_range(0, RS - 1));
      aluDr   = RW'($urandom_range(0, RS - 1));
      issueDr = RW'($urandom_range(0, RS - 1));
      ldData  = $urandom; aluData = $urandom;
      sr1     = RW'($urandom_range(0, RS - 1));
      sr2     = RW'($urandom_range(0, RS - 1));
      reset   = ($urandom_range(0, 99) == 0);
      #1;
      f1 = m_fwd(sr1); f2 = m_fwd(sr2);
      n_cmp++; if (wrtEn !== m_wen) begin n_err++; $display("FAIL rnd_wrtEn@%0d: got %b want %b", n, wrtEn, m_wen); end
      if (m_wen) begin
        n_cmp++; if ({dr, dIn} !== {m_dr, m_din})
          begin n_err++; $display("FAIL rnd_out@%0d: got %0d/%h want %0d/%h", n, dr, dIn, m_dr, m_din); end
      end
      n_cmp++; if (aluRdy !== (mq.size() < QD))
        begin n_err++; $display("FAIL rnd_rdy@%0d: got %b want %b", n, aluRdy, mq.size() < QD); end
      n_cmp++; if (pendingMask !== m_pend)
        begin n_err++; $display("FAIL rnd_pend@%0d: got %h want %h", n, pendingMask, m_pend); end
      n_cmp++; if (ovfErr !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", n, ovfErr, m_ovf); end
      n_cmp++; if ({fwd1Vld, fwd1Data} !== f1)
        begin n_err++; $display("FAIL rnd_fwd1@%0d: got %b/%h want %h", n, fwd1Vld, fwd1Data, f1); end
      n_cmp++; if ({fwd2Vld, fwd2Data} !== f2)
        begin n_err++; $display("FAIL rnd_fwd2@%0d: got %b/%h want %h", n, fwd2Vld, fwd2Data, f2); end
      n_cmp++; if (busy1 !== (m_pend[sr1] && !f1[BW]))
        begin n_err++; $display("FAIL rnd_busy1@%0d: got %b want %b", n, busy1, m_pend[sr1] && !f1[BW]); end
      n_cmp++; if (busy2 !== (m_pend[sr2] && !f2[BW]))
        begin n_err++; $display("FAIL rnd_busy2@%0d: got %b want %b", n, busy2, m_pend[sr2] && !f2[BW]); end
      step();
    end
    reset = 0; idle();
  endtask

  initial begin
    clk = 0; reset = 1; idle(); sr1 = 0; sr2 = 0;
    m_wen = 0; m_dr = 0; m_din = 0; m_pend = 0; m_ovf = 0;
    n_cmp = 0; n_err = 0;
    @(negedge clk);
    test_reset();
    test_alu_bypass();
    test_ld_alu();
    test_overflow();
    test_scoreboard();
    test_reset_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
